// File: rtl/stream_to_matrix.sv
// Assembles a stream of WIDTH-bit elements into an R x C matrix (row-major; column-major with STREAM_TO_MATRIX_COL_MAJOR_EN).
// Latency: c_valid rises 1 cycle after the final element accept.
// Backpressure: a_ready follows c_ready combinationally while a matrix is held, so the refill starts on the handoff edge.
module stream_to_matrix #(
    parameter int WIDTH = 1,
    parameter int R     = 1,
    parameter int C     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] c [R][C],
    output logic             c_valid,
    input  logic             c_ready
);

    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(C - 1);

    typedef enum logic {LOAD, FULL} state_t;

    state_t        state, state_n;
    logic [RW-1:0] row, row_n, wr_row, step_row;
    logic [CW-1:0] col, col_n, wr_col, step_col;
    logic          wr_en;
    logic          wr_last;

    // A write while FULL is always the first element of the next matrix.
    assign wr_row  = (state == FULL) ? '0 : row;
    assign wr_col  = (state == FULL) ? '0 : col;
    assign wr_last = (wr_row == ROW_LAST) && (wr_col == COL_LAST);

`ifdef STREAM_TO_MATRIX_COL_MAJOR_EN
    always_comb begin
        step_row = wr_row + 1'b1;
        step_col = wr_col;
        if (wr_row == ROW_LAST) begin
            step_row = '0;
            step_col = (wr_col == COL_LAST) ? '0 : wr_col + 1'b1;
        end
    end
`else
    always_comb begin
        step_col = wr_col + 1'b1;
        step_row = wr_row;
        if (wr_col == COL_LAST) begin
            step_col = '0;
            step_row = (wr_row == ROW_LAST) ? '0 : wr_row + 1'b1;
        end
    end
`endif

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        wr_en   = 1'b0;
        a_ready = 1'b0;
        case (state)
            LOAD: begin
                a_ready = !flush;
                if (flush) begin
                    row_n = '0;
                    col_n = '0;
                end else if (a_valid) begin
                    wr_en   = 1'b1;
                    row_n   = step_row;
                    col_n   = step_col;
                    state_n = wr_last ? FULL : LOAD;
                end
            end
            FULL: begin
                a_ready = c_ready;
                if (c_ready) begin
                    if (a_valid) begin
                        wr_en   = 1'b1;
                        row_n   = step_row;
                        col_n   = step_col;
                        // a 1x1 matrix is complete again on the same edge
                        state_n = wr_last ? FULL : LOAD;
                    end else begin
                        row_n   = '0;
                        col_n   = '0;
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

    assign c_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            row   <= '0;
            col   <= '0;
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++)
                    c[i][j] <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            if (wr_en)
                c[wr_row][wr_col] <= a;
        end
    end

endmodule

// File: tb/tb_stream_to_matrix.sv
// Randomized and directed bench for stream_to_matrix (2x3 of bytes) plus a 1x1 instance.
// Expected values come from an element-count model of the matrix fill.
module tb_stream_to_matrix;

    localparam int W = 8;
    localparam int R = 2;
    localparam int C = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush, a_valid, a_ready, c_valid, c_ready;
    logic [W-1:0] a;
    logic [W-1:0] c [R][C];

    logic         flush1, a1_valid, a1_ready, c1_valid, c1_ready;
    logic [W-1:0] a1;
    logic [W-1:0] c1 [1][1];

    always #5 clk = ~clk;

    stream_to_matrix #(.WIDTH(W), .R(R), .C(C)) dut (
        .clk(clk), .rst(rst), .flush(flush), .a(a), .a_valid(a_valid),
        .a_ready(a_ready), .c(c), .c_valid(c_valid), .c_ready(c_ready)
    );

    stream_to_matrix #(.WIDTH(W), .R(1), .C(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .a(a1), .a_valid(a1_valid),
        .a_ready(a1_ready), .c(c1), .c_valid(c1_valid), .c_ready(c1_ready)
    );

    // Model: matrix contents, number of elements accepted into the current matrix, full flag.
    logic [W-1:0] m [R][C];
    int           n;
    bit           full;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_dut();
        logic [63:0] v = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                v[(i*C+j)*W +: W] = c[i][j];
        return v;
    endfunction

    function automatic logic [63:0] pack_model();
        logic [63:0] v = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                v[(i*C+j)*W +: W] = m[i][j];
        return v;
    endfunction

    task automatic pos(input int k, output int r, output int cc);
`ifdef STREAM_TO_MATRIX_COL_MAJOR_EN
        r  = k % R;
        cc = k / R;
`else
        r  = k / C;
        cc = k % C;
`endif
    endtask

    task automatic model_reset();
        n    = 0;
        full = 1'b0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                m[i][j] = '0;
    endtask

    // Called with clock low and inputs applied; returns just after the next falling edge.
    task automatic cycle();
        bit exp_rdy, acc, ho;
        int r, cc;
        exp_rdy = full ? c_ready : !flush;
        #1;
        check("a_ready", 64'(a_ready), 64'(exp_rdy));
        check("c_valid", 64'(c_valid), 64'(full));
        if (full) check("c", pack_dut(), pack_model());
        acc = a_valid && exp_rdy;
        ho  = full && c_ready;
        @(posedge clk);
        if (ho) begin
            full = 1'b0;
            n    = 0;
        end else if (!full && flush) begin
            n = 0;
        end
        if (acc) begin
            pos(n, r, cc);
            m[r][cc] = a;
            n++;
            if (n == R*C) full = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic feed(input int v);
        a_valid = 1'b1;
        a       = W'(v);
        cycle();
        a_valid = 1'b0;
    endtask

    task automatic consume();
        c_ready = 1'b1;
        cycle();
        c_ready = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_cvalid"}, 64'(c_valid), 64'd0);
        check({tag, "_c"}, pack_dut(), 64'd0);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] prev;
        rst = 1'b1; flush = 1'b0; a_valid = 1'b0; a = '0; c_ready = 1'b0;
        flush1 = 1'b0; a1_valid = 1'b0; a1 = '0; c1_ready = 1'b0;
        model_reset();
        #12;
        check("rst_cvalid", 64'(c_valid), 64'd0);
        check("rst_c", pack_dut(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // fill 1..6 and hold with downstream stalled
        for (int i = 1; i <= 6; i++) feed(i);
        a_valid = 1'b1; a = 8'd77;
        repeat (3) cycle();

        // zero-bubble refill 7..12 starting on the handoff edge
        c_ready = 1'b1;
        for (int i = 7; i <= 12; i++) begin a = W'(i); cycle(); end
        c_ready = 1'b0; a_valid = 1'b0;
        repeat (2) cycle();
        consume();

        // flush after two accepts discards the offered element
        feed(1); feed(2);
        flush = 1'b1; a_valid = 1'b1; a = 8'd99;
        cycle();
        flush = 1'b0;
        for (int i = 3; i <= 8; i++) feed(i);
        cycle();
        consume();

        // gapped valid
        for (int i = 1; i <= 6; i++) begin feed(i); cycle(); end
        consume();

        // asynchronous reset mid-load and while full
        for (int i = 1; i <= 4; i++) feed(i + 20);
        async_reset("rst_mid");
        for (int i = 1; i <= 6; i++) feed(i + 30);
        cycle();
        async_reset("rst_full");
        for (int i = 1; i <= 6; i++) feed(i + 40);
        cycle();
        consume();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            a_valid = 1'($urandom_range(0, 3) != 0);
            c_ready = 1'($urandom_range(0, 2) == 0);
            flush   = 1'($urandom_range(0, 15) == 0);
            a       = W'($urandom);
            cycle();
        end
        flush = 1'b0; a_valid = 1'b0; c_ready = 1'b0;

        // 1x1 instance: continuous stream with downstream always ready
        c1_ready = 1'b1; a1_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            a1 = W'($urandom);
            prev = a1;
            #1;
            check("r1_a_ready", 64'(a1_ready), 64'd1);
            @(posedge clk);
            #1;
            check("r1_c_valid", 64'(c1_valid), 64'd1);
            check("r1_c", 64'(c1[0][0]), 64'(prev));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_to_matrix.md
STREAM_TO_MATRIX -- requirements
Module: stream_to_matrix

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per element.
REQ-002 SHALL have parameter R, default 1: matrix rows (R >= 1).
REQ-003 SHALL have parameter C, default 1: matrix columns (C >= 1).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1: synchronous abort of a partially loaded matrix.
REQ-007 SHALL have port a  input  WIDTH: streamed element.
REQ-008 SHALL have port a_valid  input  1: a holds a valid element.
REQ-009 SHALL have port a_ready  output  1: block accepts a this cycle.
REQ-010 SHALL have port c  output  [WIDTH-1:0] c[R][C]: assembled matrix, same shape as the downstream delay_m input.
REQ-011 SHALL have port c_valid  output  1: c holds a complete matrix.
REQ-012 SHALL have port c_ready  input  1: downstream consumes c this cycle.

Function
REQ-013 SHALL implement two states, LOAD and FULL; c_valid = (state == FULL).
REQ-014 SHALL define an element accept as a_valid && a_ready at a rising edge of clk; a matrix handoff as c_valid && c_ready at a rising edge of clk.
REQ-015 SHALL drive a_ready = 1 in LOAD, and a_ready = c_ready in FULL (combinational, zero-bubble refill).
REQ-016 SHALL write each accepted element to c[row][col], using row/col counters; default fill order is row-major (col increments first, wraps from C-1 to 0 with row+1).
REQ-017 SHALL, on the accept of element R*C-1 in LOAD, transition to FULL on that edge; c_valid is high in the following cycle with all R*C elements visible on c (latency 1 cycle from final accept).
REQ-018 SHALL hold c and c_valid stable in FULL while c_ready = 0.
REQ-019 SHALL, on handoff without a simultaneous accept, return to LOAD with row = col = 0.
REQ-020 SHALL, on handoff with a simultaneous accept, write a to c[0][0], return to LOAD with counters at the position after element 0 (for R*C = 1: stay in FULL).
REQ-021 SHALL leave elements not yet overwritten in the new matrix holding their previous values; c is only meaningful while c_valid = 1.
REQ-022 SHALL, when flush = 1 in LOAD, reset row/col to 0 and discard any element offered that cycle, with a_ready forced to 0 for that cycle.
REQ-023 SHALL ignore flush in FULL.
REQ-024 SHALL ignore a while a_valid = 0; no counter movement.
REQ-025 SHALL size the row and col counters as $clog2 of R and C, minimum 1 bit, with no out-of-range index ever generated.

Reset
REQ-026 SHALL, while rst = 1, asynchronously force state = LOAD, row = col = 0, c_valid = 0, and every c[i][j] = 0.
REQ-027 SHALL drive a_ready = 1 in the first cycle after rst deasserts, unless flush = 1.
REQ-028 SHALL, on rst asserted mid-load or in FULL, discard partial or complete contents with no handoff.

Configuration
REQ-029 SHALL use macro STREAM_TO_MATRIX_COL_MAJOR_EN; when defined, the fill order is column-major (row increments first, wraps from R-1 to 0 with col+1).
REQ-030 SHALL, when STREAM_TO_MATRIX_COL_MAJOR_EN is undefined, fill row-major as in REQ-016; handshake, latency and reset behaviour are identical in both builds.

Verification (WIDTH=8, R=2, C=3 unless stated)
REQ-031 SHALL verify: a_valid=1 continuous with 1..6, c_ready=0 -> c_valid high the cycle after the 6th accept; c = {{1,2,3},{4,5,6}} (col-major build: {{1,3,5},{2,4,6}}); a_ready=0 until c_ready.
REQ-032 SHALL verify: matrix full, c_ready=1 and a_valid=1 with 7..12 continuous -> handoff and accept of 7 on the same edge; the second matrix {{7,8,9},{10,11,12}} is valid exactly 6 cycles later with no bubble.
REQ-033 SHALL verify: accept 1,2, then flush=1 with a_valid=1, a=99 -> 99 not accepted; next accepts 3..8 give c = {{3,4,5},{6,7,8}}.
REQ-034 SHALL verify: a_valid toggled 1/0 every cycle with 1..6 -> same matrix as REQ-031, c_valid after 6th accept only.
REQ-035 SHALL verify: rst pulsed asynchronously (between clk edges) after 4 accepts and again while FULL -> c_valid=0, all c=0 immediately; next six accepts form a fresh matrix.
REQ-036 SHALL verify: R=1, C=1, a_valid=1 continuous, c_ready=1 -> c_valid stays 1, c updates to each new element every cycle, a_ready=1 throughout.
